sram_test_sequencer: RTL
========================

Name: sram_test_sequencer

Overview:
- Client-side initiator that drives the SRAM controller's request interface: start_operation, rw, address and write data.
- Fills an address range with a selectable data pattern, then reads the range back and compares every byte.
- Reports pass/fail, the error count and the first failing location.
- Sits between the board-level test control (buttons/UART command decoder) and the SRAM controller on the Cmod A7-35T.

Parameters:
TIMEOUT_CYCLES, 16, max cycles waited for any single controller busy edge before aborting
COUNT_WIDTH, 20, width of error_count

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
test_start  input  1  one-cycle request to begin a test run; ignored while test_busy=1
address_first  input  19  first address of range, sampled on accepted test_start
address_last  input  19  last address of range (inclusive), sampled on accepted test_start
pattern_select  input  2  0: addr[7:0]^seed, 1: seed, 2: addr[0]?~seed:seed, 3: ~addr[7:0]
seed  input  8  pattern seed, sampled on accepted test_start
start_operation  output  1  one-cycle access request to controller
rw  output  1  1=read, 0=write
address_input  output  19  access address to controller
data_f2s  output  8  write data to controller
data_s2f  input  8  read data from controller
data_ready_signal_output  input  1  controller read-data-valid flag
busy_signal_output  input  1  controller busy flag
test_busy  output  1  run in progress
test_done  output  1  one-cycle pulse at end of run
test_pass  output  1  valid from test_done until next accepted test_start
config_error  output  1  address_first > address_last on last start
timeout_error  output  1  controller handshake timed out on last run
error_count  output  COUNT_WIDTH  mismatches in last run, saturating
first_error_address  output  19  address of first mismatch
first_error_expected  output  8  expected byte at first mismatch
first_error_read  output  8  byte read at first mismatch

Behaviour:
- Reset values: all outputs 0; rw=1; state IDLE. Async reset mid-run drops start_operation immediately and aborts the run with no test_done.
- States: IDLE, WR_WAIT_BUSY, WR_WAIT_IDLE, WR_NEXT, RD_WAIT_BUSY, RD_WAIT_IDLE, RD_CHECK, DONE.
- IDLE, test_start=1:
  - Latch range, pattern and seed.
  - Clear error_count, first_error_*, config_error, timeout_error and test_pass.
  - If first>last: set config_error=1 and go to DONE with test_pass=0 and no accesses.
  - Otherwise set cur_addr=first, rw=0, data_f2s=pattern(cur_addr), pulse start_operation and go to WR_WAIT_BUSY.
- start_operation is registered and high for exactly one cycle per access. address_input/data_f2s/rw are stable from that cycle until the matching busy falling edge is seen.
- *_WAIT_BUSY: wait for busy_signal_output=1, then go to *_WAIT_IDLE. A low busy in the first cycles after start is expected (the controller asserts busy 2 cycles after sampling start) and must not be treated as completion.
- RD_WAIT_IDLE: on any cycle with data_ready_signal_output=1, capture data_s2f into rd_capture.
- Busy=0 observed:
  - From WR_WAIT_IDLE, go to WR_NEXT.
  - From RD_WAIT_IDLE, go to RD_CHECK. If no data_ready was seen during the access, count it as a mismatch with read value 0x00.
- WR_NEXT:
  - If cur_addr==address_last: set cur_addr=first, rw=1, pulse start and go to RD_WAIT_BUSY.
  - Otherwise increment cur_addr, set data_f2s, pulse start and go to WR_WAIT_BUSY.
- RD_CHECK:
  - Compare rd_capture with pattern(cur_addr). On mismatch, increment error_count (saturating at all-ones); on the first mismatch of the run, also record address/expected/read.
  - Then advance as in WR_NEXT, or go to DONE after address_last.
- End-address compare is done before incrementing; address_last=0x7FFFF must not wrap to 0.
- Timeout: per-wait counter reset on each state entry. Reaching TIMEOUT_CYCLES in any WAIT state sets timeout_error=1 and goes to DONE with test_pass=0.
- DONE: pulse test_done for 1 cycle, set test_pass = (error_count==0 && !timeout_error && !config_error), return to IDLE.
- test_busy=1 in every state except IDLE. test_start during a run has no effect.
- Access cadence: the next start is issued in the cycle after busy low is observed.

Test Plan:
- Range 0x00010..0x00013, pattern 0, seed 0xA5, behavioural SRAM+controller -> 4 writes with data 0xB5,0xB4,0xB7,0xB6, then 4 reads; test_done once, test_pass=1, error_count=0.
- Same run with the SRAM model forcing address 0x00012 to read 0x00 -> error_count=1, first_error_address=0x00012, expected=0xB7, read=0x00, test_pass=0.
- address_first=0x00020, address_last=0x0001F -> no start_operation pulses, config_error=1, test_done one cycle after start, test_pass=0.
- Range 0x7FFFE..0x7FFFF, pattern 3 -> writes 0x01 then 0x00, reads the same 2 addresses, terminates (no wrap to 0x00000), pass=1.
- Controller busy stuck at 0 -> timeout_error=1 after 16 cycles in WR_WAIT_BUSY, test_pass=0, test_busy=0 afterwards.
- Reset asserted mid read phase -> all outputs return to 0 (rw=1) asynchronously, no test_done; a new test_start then runs normally.

Source files
------------

// File: rtl/sram_test_sequencer.sv
// Fill-then-verify sequencer: writes a pattern over an address range through the SRAM controller, reads it back, tallies mismatches.
// One access in flight at a time; each access waits on the controller's busy rise/fall and aborts after TIMEOUT_CYCLES per wait.
module sram_test_sequencer #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int COUNT_WIDTH    = 20
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   test_start,
  input  logic [18:0]            address_first,
  input  logic [18:0]            address_last,
  input  logic [1:0]             pattern_select,
  input  logic [7:0]             seed,
  output logic                   start_operation,
  output logic                   rw,
  output logic [18:0]            address_input,
  output logic [7:0]             data_f2s,
  input  logic [7:0]             data_s2f,
  input  logic                   data_ready_signal_output,
  input  logic                   busy_signal_output,
  output logic                   test_busy,
  output logic                   test_done,
  output logic                   test_pass,
  output logic                   config_error,
  output logic                   timeout_error,
  output logic [COUNT_WIDTH-1:0] error_count,
  output logic [18:0]            first_error_address,
  output logic [7:0]             first_error_expected,
  output logic [7:0]             first_error_read
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, WR_WAIT_BUSY, WR_WAIT_IDLE, WR_NEXT,
    RD_WAIT_BUSY, RD_WAIT_IDLE, RD_CHECK, DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [18:0]            cur_q, cur_d;
  logic [18:0]            first_q, first_d;
  logic [18:0]            last_q, last_d;
  logic [1:0]             pat_q, pat_d;
  logic [7:0]             seed_q, seed_d;
  logic                   start_q, start_d;
  logic                   rw_q, rw_d;
  logic [7:0]             data_q, data_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [7:0]             cap_q, cap_d;
  logic                   seen_q, seen_d;
  logic [COUNT_WIDTH-1:0] err_q, err_d;
  logic [18:0]            fe_addr_q, fe_addr_d;
  logic [7:0]             fe_exp_q, fe_exp_d;
  logic [7:0]             fe_rd_q, fe_rd_d;
  logic                   pass_q, pass_d;
  logic                   cfg_q, cfg_d;
  logic                   to_q, to_d;

  function automatic logic [7:0] pattern_f(input logic [1:0] sel, input logic [7:0] sd,
                                           input logic [18:0] addr);
    case (sel)
      2'd0:    return addr[7:0] ^ sd;
      2'd1:    return sd;
      2'd2:    return addr[0] ? ~sd : sd;
      default: return ~addr[7:0];
    endcase
  endfunction

  logic [18:0] next_addr;
  logic [7:0]  exp_byte;
  logic [7:0]  rd_byte;
  logic        mismatch;
  logic        timer_hit;

  always_comb begin
    next_addr = cur_q + 19'd1;
    exp_byte  = pattern_f(pat_q, seed_q, cur_q);
    // An access that never raised data_ready reads as 0x00 and always counts as a miss.
    rd_byte   = seen_q ? cap_q : 8'h00;
    mismatch  = !seen_q || (cap_q != exp_byte);
    timer_hit = (timer_q == TW'(TIMEOUT_CYCLES - 1));
  end

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    first_d   = first_q;
    last_d    = last_q;
    pat_d     = pat_q;
    seed_d    = seed_q;
    start_d   = 1'b0;
    rw_d      = rw_q;
    data_d    = data_q;
    timer_d   = '0;
    cap_d     = cap_q;
    seen_d    = seen_q;
    err_d     = err_q;
    fe_addr_d = fe_addr_q;
    fe_exp_d  = fe_exp_q;
    fe_rd_d   = fe_rd_q;
    pass_d    = pass_q;
    cfg_d     = cfg_q;
    to_d      = to_q;

    case (state_q)
      IDLE: begin
        if (test_start) begin
          first_d   = address_first;
          last_d    = address_last;
          pat_d     = pattern_select;
          seed_d    = seed;
          err_d     = '0;
          fe_addr_d = '0;
          fe_exp_d  = '0;
          fe_rd_d   = '0;
          cfg_d     = 1'b0;
          to_d      = 1'b0;
          pass_d    = 1'b0;
          if (address_first > address_last) begin
            cfg_d   = 1'b1;
            state_d = DONE;
          end else begin
            cur_d   = address_first;
            rw_d    = 1'b0;
            data_d  = pattern_f(pattern_select, seed, address_first);
            start_d = 1'b1;
            state_d = WR_WAIT_BUSY;
          end
        end
      end

      WR_WAIT_BUSY, RD_WAIT_BUSY: begin
        if (busy_signal_output) begin
          state_d = (state_q == WR_WAIT_BUSY) ? WR_WAIT_IDLE : RD_WAIT_IDLE;
        end else if (timer_hit) begin
          to_d    = 1'b1;
          state_d = DONE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      WR_WAIT_IDLE: begin
        if (!busy_signal_output) begin
          state_d = WR_NEXT;
        end else if (timer_hit) begin
          to_d    = 1'b1;
          state_d = DONE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      RD_WAIT_IDLE: begin
        if (data_ready_signal_output) begin
          cap_d  = data_s2f;
          seen_d = 1'b1;
        end
        if (!busy_signal_output) begin
          state_d = RD_CHECK;
        end else if (timer_hit) begin
          to_d    = 1'b1;
          state_d = DONE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      WR_NEXT: begin
        start_d = 1'b1;
        if (cur_q == last_q) begin
          cur_d   = first_q;
          rw_d    = 1'b1;
          seen_d  = 1'b0;
          cap_d   = 8'h00;
          state_d = RD_WAIT_BUSY;
        end else begin
          cur_d   = next_addr;
          data_d  = pattern_f(pat_q, seed_q, next_addr);
          state_d = WR_WAIT_BUSY;
        end
      end

      RD_CHECK: begin
        if (mismatch) begin
          if (err_q != {COUNT_WIDTH{1'b1}}) err_d = err_q + COUNT_WIDTH'(1);
          if (err_q == '0) begin
            fe_addr_d = cur_q;
            fe_exp_d  = exp_byte;
            fe_rd_d   = rd_byte;
          end
        end
        // Equality check before incrementing keeps 0x7FFFF from wrapping.
        if (cur_q == last_q) begin
          pass_d  = (err_d == '0) && !to_q && !cfg_q;
          state_d = DONE;
        end else begin
          cur_d   = next_addr;
          start_d = 1'b1;
          seen_d  = 1'b0;
          cap_d   = 8'h00;
          state_d = RD_WAIT_BUSY;
        end
      end

      DONE: begin
        rw_d    = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cur_q     <= '0;
      first_q   <= '0;
      last_q    <= '0;
      pat_q     <= '0;
      seed_q    <= '0;
      start_q   <= 1'b0;
      rw_q      <= 1'b1;
      data_q    <= '0;
      timer_q   <= '0;
      cap_q     <= '0;
      seen_q    <= 1'b0;
      err_q     <= '0;
      fe_addr_q <= '0;
      fe_exp_q  <= '0;
      fe_rd_q   <= '0;
      pass_q    <= 1'b0;
      cfg_q     <= 1'b0;
      to_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      first_q   <= first_d;
      last_q    <= last_d;
      pat_q     <= pat_d;
      seed_q    <= seed_d;
      start_q   <= start_d;
      rw_q      <= rw_d;
      data_q    <= data_d;
      timer_q   <= timer_d;
      cap_q     <= cap_d;
      seen_q    <= seen_d;
      err_q     <= err_d;
      fe_addr_q <= fe_addr_d;
      fe_exp_q  <= fe_exp_d;
      fe_rd_q   <= fe_rd_d;
      pass_q    <= pass_d;
      cfg_q     <= cfg_d;
      to_q      <= to_d;
    end
  end

  assign start_operation      = start_q;
  assign rw                   = rw_q;
  assign address_input        = cur_q;
  assign data_f2s             = data_q;
  assign test_busy            = (state_q != IDLE);
  assign test_done            = (state_q == DONE);
  assign test_pass            = pass_q;
  assign config_error         = cfg_q;
  assign timeout_error        = to_q;
  assign error_count          = err_q;
  assign first_error_address  = fe_addr_q;
  assign first_error_expected = fe_exp_q;
  assign first_error_read     = fe_rd_q;

endmodule
